// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned MD_CNT_W = 4;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks an in-flight multiply/divide: MD_WAIT state plus a down-counter
// that returns to RUN once the HI/LO result is valid.
module md_busy_timer
  import hazard_pkg::*;
(
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                start,
  input  logic [MD_CNT_W-1:0] load_val,
  output logic                busy
);

  md_state_e           state;
  logic [MD_CNT_W-1:0] md_cnt;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            md_cnt <= load_val;
            state  <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          // A start here is illegal upstream; reload rather than lose it.
          if (start) begin
            md_cnt <= load_val;
          end else if (md_cnt == MD_CNT_W'(1)) begin
            md_cnt <= '0;
            state  <= RUN;
          end else begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          md_cnt <= '0;
          state  <= RUN;
        end
      endcase
    end
  end

  assign busy = (state == MD_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and mult/div
// stalls, branch/jump redirect. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        ID_ReadsHiLo,
  input  logic        ID_IsMulDiv,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        MD_Start,
`ifdef HAZARD_STATS_EN
  output logic [15:0] STALL_COUNT,
  output logic [15:0] FLUSH_COUNT,
`endif
  output logic        PC_WRITE,
  output logic        IFID_STALL,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        MD_BUSY
);

  logic busy;
  logic luh;
  logic mdh;
  logic stall;
  logic redirect;

  md_busy_timer u_md_busy_timer (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .start    (MD_Start),
    .load_val (MD_CNT_W'(MD_LATENCY - 1)),
    .busy     (busy)
  );

  assign MD_BUSY = busy;

  assign luh = EX_MemRead && (EX_Rt != REG_ZERO) &&
               ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  assign mdh      = busy && (ID_ReadsHiLo || ID_IsMulDiv);
  assign stall    = luh || mdh;
  assign redirect = ID_BranchTaken || ID_Jump;

  // Stall outranks redirect so a branch with stale operands is not taken.
  always_comb begin
    PC_WRITE   = 1'b0;
    IFID_STALL = 1'b0;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    if (RESET) begin
      if (stall) begin
        IFID_STALL = 1'b1;
        IDEX_FLUSH = 1'b1;
      end else if (redirect) begin
        PC_WRITE   = 1'b1;
        IFID_FLUSH = 1'b1;
      end else begin
        PC_WRITE   = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (stall && (STALL_COUNT != 16'hFFFF))
        STALL_COUNT <= STALL_COUNT + 16'd1;
      if (IFID_FLUSH && (FLUSH_COUNT != 16'hFFFF))
        FLUSH_COUNT <= FLUSH_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors with literal
// expectations plus a cycle-by-cycle behavioural model comparison.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic [4:0] ID_Rs = '0;
  logic [4:0] ID_Rt = '0;
  logic       ID_UsesRt = 1'b0;
  logic       ID_BranchTaken = 1'b0;
  logic       ID_Jump = 1'b0;
  logic       ID_ReadsHiLo = 1'b0;
  logic       ID_IsMulDiv = 1'b0;
  logic       EX_MemRead = 1'b0;
  logic [4:0] EX_Rt = '0;
  logic       MD_Start = 1'b0;
  logic       PC_WRITE, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, MD_BUSY;
`ifdef HAZARD_STATS_EN
  logic [15:0] STALL_COUNT, FLUSH_COUNT;
`endif

  int tests = 0;
  int fails = 0;

  // Model: cycles of mult/div still outstanding, and event totals.
  int rem = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_BranchTaken (ID_BranchTaken),
    .ID_Jump        (ID_Jump),
    .ID_ReadsHiLo   (ID_ReadsHiLo),
    .ID_IsMulDiv    (ID_IsMulDiv),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .MD_Start       (MD_Start),
`ifdef HAZARD_STATS_EN
    .STALL_COUNT    (STALL_COUNT),
    .FLUSH_COUNT    (FLUSH_COUNT),
`endif
    .PC_WRITE       (PC_WRITE),
    .IFID_STALL     (IFID_STALL),
    .IFID_FLUSH     (IFID_FLUSH),
    .IDEX_FLUSH     (IDEX_FLUSH),
    .MD_BUSY        (MD_BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic model_stall(input int r);
    logic luh;
    luh = EX_MemRead && (EX_Rt != 5'd0) &&
          ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    return luh || ((r > 0) && (ID_ReadsHiLo || ID_IsMulDiv));
  endfunction

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rem       <= 0;
      m_stalls  <= 0;
      m_flushes <= 0;
    end else begin
      if (model_stall(rem)) begin
        if (m_stalls < 65535) m_stalls <= m_stalls + 1;
      end else if (ID_BranchTaken || ID_Jump) begin
        if (m_flushes < 65535) m_flushes <= m_flushes + 1;
      end
      if (MD_Start) rem <= int'(LAT) - 1;
      else if (rem > 0) rem <= rem - 1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [4:0] exp;
    logic busy;
    busy = (rem > 0);
    if (!RESET) exp = 5'b00000;
    else if (model_stall(rem)) exp = {1'b0, 1'b1, 1'b0, 1'b1, busy};
    else if (ID_BranchTaken || ID_Jump) exp = {1'b1, 1'b0, 1'b1, 1'b0, busy};
    else exp = {1'b1, 1'b0, 1'b0, 1'b0, busy};
    check("model{pcw,stall,flush,idex,busy}", 16'({PC_WRITE, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, MD_BUSY}), 16'(exp));
`ifdef HAZARD_STATS_EN
    check("model_stall_count", STALL_COUNT, 16'(m_stalls));
    check("model_flush_count", FLUSH_COUNT, 16'(m_flushes));
`endif
  endtask

  // Apply one cycle of inputs just after the edge, then check at the falling edge.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic br, input logic jmp, input logic hilo, input logic md,
                     input logic memrd, input logic [4:0] exrt, input logic start);
    @(posedge CLOCK);
    #1;
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses; ID_BranchTaken = br; ID_Jump = jmp;
    ID_ReadsHiLo = hilo; ID_IsMulDiv = md; EX_MemRead = memrd; EX_Rt = exrt; MD_Start = start;
    @(negedge CLOCK);
    model_check();
  endtask

  task automatic idle();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLOCK);
    model_check();
    check("rst_pc_write", 16'(PC_WRITE), 16'd0);
    check("rst_md_busy", 16'(MD_BUSY), 16'd0);
    check("rst_idex_flush", 16'(IDEX_FLUSH), 16'd0);
    RESET = 1'b1;
    idle();
    check("run_pc_write", 16'(PC_WRITE), 16'd1);

    // Load-use on rs, one cycle
    cyc(5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
    check("luh_pc_write", 16'(PC_WRITE), 16'd0);
    check("luh_ifid_stall", 16'(IFID_STALL), 16'd1);
    check("luh_idex_flush", 16'(IDEX_FLUSH), 16'd1);
    cyc(5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("luh_clear_pc_write", 16'(PC_WRITE), 16'd1);

    // Register zero and unused rt never stall
    cyc(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    check("zero_reg_pc_write", 16'(PC_WRITE), 16'd1);
    cyc(5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    check("unused_rt_pc_write", 16'(PC_WRITE), 16'd1);
    cyc(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    check("used_rt_stall", 16'(IFID_STALL), 16'd1);

    // Branch redirect, single cycle
    cyc(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("br_ifid_flush", 16'(IFID_FLUSH), 16'd1);
    check("br_pc_write", 16'(PC_WRITE), 16'd1);
    idle();
    check("br_after_flush", 16'(IFID_FLUSH), 16'd0);

    // Stall beats branch, then branch resolves
    cyc(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    check("br_luh_stall", 16'(IFID_STALL), 16'd1);
    check("br_luh_flush", 16'(IFID_FLUSH), 16'd0);
    cyc(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("br_retry_flush", 16'(IFID_FLUSH), 16'd1);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("jump_flush", 16'(IFID_FLUSH), 16'd1);

    // Mult/div: start at cycle 0, mfhi waits cycles 1-3, proceeds cycle 4
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    check("md_c0_busy", 16'(MD_BUSY), 16'd0);
    check("md_c0_pc_write", 16'(PC_WRITE), 16'd1);
    for (int c = 1; c <= 3; c++) begin
      cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      check($sformatf("md_c%0d_busy", c), 16'(MD_BUSY), 16'd1);
      check($sformatf("md_c%0d_pc_write", c), 16'(PC_WRITE), 16'd0);
    end
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check("md_c4_busy", 16'(MD_BUSY), 16'd0);
    check("md_c4_pc_write", 16'(PC_WRITE), 16'd1);

    // New mult/div while busy is held off
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("md_on_md_stall", 16'(IFID_STALL), 16'd1);

    // Asynchronous reset during MD_WAIT
    @(posedge CLOCK);
    #1;
    ID_IsMulDiv = 1'b0;
    RESET = 1'b0;
    #1;
    check("rst_mid_md_busy", 16'(MD_BUSY), 16'd0);
    check("rst_mid_pc_write", 16'(PC_WRITE), 16'd0);
    @(negedge CLOCK);
    model_check();
    @(negedge CLOCK);
    RESET = 1'b1;
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    check("post_rst_pc_write", 16'(PC_WRITE), 16'd1);
    check("post_rst_busy", 16'(MD_BUSY), 16'd0);
`ifdef HAZARD_STATS_EN
    check("post_rst_stall_count", STALL_COUNT, 16'd0);
    check("post_rst_flush_count", FLUSH_COUNT, 16'd0);
`endif

    // Mixed vectors over a small register range, checked against the model
    for (int i = 0; i < 80; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
